// File: rtl/el2_dccm_req_ctl_if.sv
// Purpose: word-request / response channel between a DMA/debug-style
// requester and the DCCM request controller.
// Signals:
//   req_valid/req_ready       request handshake (accept when both high)
//   req_write/size/addr/wdata request payload (size 0=byte 1=half 2=word)
//   rsp_valid/rsp_ready       response handshake (rsp held until ready)
//   rsp_rdata/rsp_err         response payload
//   busy                      controller not idle or response pending
// Modports: master = requester side, slave = controller side.
interface el2_dccm_req_ctl_if #(
  parameter int unsigned DCCM_BITS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [1:0]           req_size;
  logic [DCCM_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/el2_dccm_req_ctl.sv
// Purpose: single-port DCCM requester. Turns valid/ready word requests into
// DCCM read/write strobes; aligned words go straight through, byte/half
// writes are done as read-modify-write with fresh 7-bit SECDED ECC.
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   req_if (slave)           request/response channel, see interface file
//   dccm_rden / dccm_wren    one-cycle DCCM read / write strobes
//   dccm_rd_addr_lo/hi       word-aligned read address (same on both banks)
//   dccm_wr_addr_lo/hi       word-aligned write address (same on both banks)
//   dccm_wr_data_lo/hi       {ecc[6:0], data[31:0]} (same on both banks)
//   dccm_rd_data_lo          read data, valid the cycle after dccm_rden
//   dccm_rd_data_hi          unused
module el2_dccm_req_ctl #(
  parameter int unsigned DCCM_BITS        = 16,
  parameter int unsigned DCCM_FDATA_WIDTH = 39
) (
  input  logic                        clk,
  input  logic                        rst,
  el2_dccm_req_ctl_if.slave           req_if,
  output logic                        dccm_rden,
  output logic                        dccm_wren,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi
);

  localparam int unsigned DW   = 32;
  localparam int unsigned ECCW = 7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WAIT,
    ST_RMW_WR,
    ST_ERR,
    ST_RSP
  } state_e;

  // SECDED check bits for a 32-bit word (Hamming positions + overall parity)
  function automatic logic [ECCW-1:0] rvecc_encode(input logic [DW-1:0] din);
    logic [ECCW-1:0] ecc;
    ecc[0] = din[0]^din[1]^din[3]^din[4]^din[6]^din[8]^din[10]^din[11]^din[13]^din[15]
           ^ din[17]^din[19]^din[21]^din[23]^din[25]^din[26]^din[28]^din[30];
    ecc[1] = din[0]^din[2]^din[3]^din[5]^din[6]^din[9]^din[10]^din[12]^din[13]^din[16]
           ^ din[17]^din[20]^din[21]^din[24]^din[25]^din[27]^din[28]^din[31];
    ecc[2] = din[1]^din[2]^din[3]^din[7]^din[8]^din[9]^din[10]^din[14]^din[15]^din[16]
           ^ din[17]^din[22]^din[23]^din[24]^din[25]^din[29]^din[30]^din[31];
    ecc[3] = din[4]^din[5]^din[6]^din[7]^din[8]^din[9]^din[10]^din[18]^din[19]^din[20]
           ^ din[21]^din[22]^din[23]^din[24]^din[25];
    ecc[4] = din[11]^din[12]^din[13]^din[14]^din[15]^din[16]^din[17]^din[18]^din[19]
           ^ din[20]^din[21]^din[22]^din[23]^din[24]^din[25];
    ecc[5] = din[26]^din[27]^din[28]^din[29]^din[30]^din[31];
    ecc[6] = (^din) ^ (^ecc[5:0]);
    return ecc;
  endfunction

  // Select the addressed byte/half of a word, zero-extended
  function automatic logic [DW-1:0] lane_extract(input logic [DW-1:0] w,
                                                 input logic [1:0]    sz,
                                                 input logic [1:0]    off);
    logic [DW-1:0] r;
    r = '0;
    case (sz)
      SZ_BYTE: begin
        case (off)
          2'd0:    r = {24'd0, w[7:0]};
          2'd1:    r = {24'd0, w[15:8]};
          2'd2:    r = {24'd0, w[23:16]};
          default: r = {24'd0, w[31:24]};
        endcase
      end
      SZ_HALF: r = off[1] ? {16'd0, w[31:16]} : {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overlay the low byte/half of wd onto the addressed lane of w
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] w,
                                               input logic [DW-1:0] wd,
                                               input logic [1:0]    sz,
                                               input logic [1:0]    off);
    logic [DW-1:0] r;
    r = w;
    case (sz)
      SZ_BYTE: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  state_e               state_q, state_d;
  logic [DCCM_BITS-1:0] addr_q,  addr_d;
  logic [1:0]           size_q,  size_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW-1:0]        word_q,  word_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 err_q,   err_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 busy_q,  busy_d;

  logic                 accept_c;
  logic                 illegal_c;
  logic [DW-1:0]        rd_word_c;
  logic [DCCM_BITS-1:0] word_addr_c;
  logic [DCCM_FDATA_WIDTH-1:0] wr_full_c;
  logic                 unused_rd_bits;

  assign accept_c  = req_if.req_valid && req_if.req_ready;
  assign rd_word_c = dccm_rd_data_lo[DW-1:0];

  // Stored ECC and the hi bank are checked elsewhere
  assign unused_rd_bits = ^{dccm_rd_data_hi, dccm_rd_data_lo[DCCM_FDATA_WIDTH-1:DW]};

  // Size 3, odd halfword or non-word-aligned word
  always_comb begin
    illegal_c = 1'b0;
    case (req_if.req_size)
      SZ_BYTE: illegal_c = 1'b0;
      SZ_HALF: illegal_c = req_if.req_addr[0];
      SZ_WORD: illegal_c = (req_if.req_addr[1:0] != 2'b00);
      default: illegal_c = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; reset abandons any in-flight access
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (illegal_c)                       state_d = ST_ERR;
          else if (!req_if.req_write)          state_d = ST_RD;
          else if (req_if.req_size == SZ_WORD) state_d = ST_WR;
          else                                 state_d = ST_RMW_RD;
        end
      end
      ST_RD:       state_d = ST_RD_WAIT;
      ST_RD_WAIT:  state_d = ST_RSP;
      ST_WR:       state_d = ST_RSP;
      ST_RMW_RD:   state_d = ST_RMW_WAIT;
      ST_RMW_WAIT: state_d = ST_RMW_WR;
      ST_RMW_WR:   state_d = ST_RSP;
      ST_ERR:      state_d = ST_RSP;
      ST_RSP:      if (req_if.rsp_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (rst) state_d = ST_IDLE;
  end

  // Outputs; strobes are gated by rst so a reset cycle never touches memory
  always_comb begin
    rsp_valid_d = 1'b0;
    busy_d      = 1'b0;
    dccm_rden   = 1'b0;
    dccm_wren   = 1'b0;
    req_if.req_ready = 1'b0;
    rsp_valid_d = (state_d == ST_ERR) || (state_d == ST_RSP);
    busy_d      = (state_d != ST_IDLE);
    dccm_rden   = ((state_q == ST_RD) || (state_q == ST_RMW_RD)) && !rst;
    dccm_wren   = ((state_q == ST_WR) || (state_q == ST_RMW_WR)) && !rst;
    req_if.req_ready = (state_q == ST_IDLE) && !rsp_valid_q && !rst;
  end

  // Datapath: latch the request, capture read data, merge RMW lanes
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept_c) begin
      addr_d  = req_if.req_addr;
      size_d  = req_if.req_size;
      wdata_d = req_if.req_wdata;
      word_d  = req_if.req_wdata;
      rdata_d = '0;
      err_d   = illegal_c;
    end
    if (state_q == ST_RD_WAIT) begin
      rdata_d = lane_extract(rd_word_c, size_q, addr_q[1:0]);
    end
    if (state_q == ST_RMW_WAIT) begin
      word_d = lane_merge(rd_word_c, wdata_q, size_q, addr_q[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign word_addr_c = {addr_q[DCCM_BITS-1:2], 2'b00};
  assign wr_full_c   = DCCM_FDATA_WIDTH'({rvecc_encode(word_q), word_q});

  assign dccm_rd_addr_lo = word_addr_c;
  assign dccm_rd_addr_hi = word_addr_c;
  assign dccm_wr_addr_lo = word_addr_c;
  assign dccm_wr_addr_hi = word_addr_c;
  assign dccm_wr_data_lo = wr_full_c;
  assign dccm_wr_data_hi = wr_full_c;

  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rdata_q;
  assign req_if.rsp_err   = err_q;
  assign req_if.busy      = busy_q;

endmodule

// File: tb/tb_el2_dccm_req_ctl.sv
// Purpose: randomized self-checking bench for el2_dccm_req_ctl. A DCCM
// memory sits behind the DUT; a word-level reference memory predicts read
// data, merged write words, ECC, strobe timing and response latency.
module tb_el2_dccm_req_ctl;

  localparam int unsigned AW = 16;
  localparam int unsigned FW = 39;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  el2_dccm_req_ctl_if #(.DCCM_BITS(AW)) bus ();

  logic          dccm_rden, dccm_wren;
  logic [AW-1:0] dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi;
  logic [FW-1:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic [FW-1:0] dccm_rd_data_lo = '0;
  logic [FW-1:0] dccm_rd_data_hi = '0;

  logic [FW-1:0] mem     [0:16383];
  logic [31:0]   ref_mem [0:16383];
  logic [31:0]   last_rdata;

  int checks = 0;
  int errors = 0;

  el2_dccm_req_ctl #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(FW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_if          (bus),
    .dccm_rden       (dccm_rden),
    .dccm_wren       (dccm_wren),
    .dccm_rd_addr_lo (dccm_rd_addr_lo),
    .dccm_rd_addr_hi (dccm_rd_addr_hi),
    .dccm_wr_addr_lo (dccm_wr_addr_lo),
    .dccm_wr_addr_hi (dccm_wr_addr_hi),
    .dccm_wr_data_lo (dccm_wr_data_lo),
    .dccm_wr_data_hi (dccm_wr_data_hi),
    .dccm_rd_data_lo (dccm_rd_data_lo),
    .dccm_rd_data_hi (dccm_rd_data_hi)
  );

  // DCCM model: one-cycle read latency; returned ECC is scrambled since the
  // requester must ignore it, and the hi bank carries junk
  always @(posedge clk) begin
    if (dccm_rden) dccm_rd_data_lo <= mem[dccm_rd_addr_lo[AW-1:2]] ^ {7'($urandom), 32'd0};
    dccm_rd_data_hi <= {7'($urandom), $urandom};
    if (dccm_wren) mem[dccm_wr_addr_lo[AW-1:2]] <= dccm_wr_data_lo;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hamming SECDED: data bits occupy the non-power-of-two positions 3,5,6,7,9...
  // check bit k covers positions with bit k set; bit 6 is overall parity
  function automatic logic [6:0] ecc_ref(input logic [31:0] d);
    logic [6:0] e;
    int pos;
    int di;
    e = '0;
    pos = 0;
    di = 0;
    while (di < 32) begin
      pos++;
      if ((pos & (pos - 1)) != 0) begin
        if (d[di]) begin
          for (int k = 0; k < 6; k++) if (((pos >> k) & 1) != 0) e[k] = ~e[k];
        end
        di++;
      end
    end
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  task automatic do_txn(input logic w, input logic [1:0] sz, input logic [15:0] a,
                        input logic [31:0] wd);
    logic        ill;
    int          idx, sh, n, rsp_cyc, rd_n, wr_n, rd_cyc, wr_cyc, hold;
    int          exp_rsp, exp_rd_cyc, exp_wr_cyc;
    logic [31:0] mask, old, newv, exp_rdata;
    logic [15:0] exp_a;
    logic [38:0] wr_seen, exp_wr;
    ill  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    idx  = int'(a >> 2);
    sh   = 8 * int'(a[1:0]);
    mask = (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    old  = ref_mem[idx];
    newv = (old & ~(mask << sh)) | ((wd & mask) << sh);
    exp_rdata  = (ill || w) ? 32'd0 : ((old >> sh) & mask);
    exp_a      = a & 16'hFFFC;
    exp_wr     = (!ill && w) ? {ecc_ref(newv), newv} : 39'd0;
    exp_rsp    = ill ? 1 : (!w ? 3 : (sz == 2'd2 ? 2 : 4));
    exp_rd_cyc = (!ill && (!w || sz != 2'd2)) ? 1 : 0;
    exp_wr_cyc = (ill || !w) ? 0 : (sz == 2'd2 ? 1 : 3);

    @(negedge clk);
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(bus.req_ready), 64'd1);

    rsp_cyc = 0; rd_n = 0; wr_n = 0; rd_cyc = 0; wr_cyc = 0; wr_seen = '0;
    for (int k = 1; k <= 12 && rsp_cyc == 0; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("strobe_excl", 64'(dccm_rden & dccm_wren), 64'd0);
      if (dccm_rden) begin
        rd_n++;
        rd_cyc = k;
        check("rd_addr_lo", 64'(dccm_rd_addr_lo), 64'(exp_a));
        check("rd_addr_hi", 64'(dccm_rd_addr_hi), 64'(exp_a));
      end
      if (dccm_wren) begin
        wr_n++;
        wr_cyc  = k;
        wr_seen = dccm_wr_data_lo;
        check("wr_addr_lo", 64'(dccm_wr_addr_lo), 64'(exp_a));
        check("wr_addr_hi", 64'(dccm_wr_addr_hi), 64'(exp_a));
        check("wr_data_hi", 64'(dccm_wr_data_hi), 64'(exp_wr));
      end
      if (bus.rsp_valid) rsp_cyc = k;
    end
    check("rsp_latency", 64'(rsp_cyc), 64'(exp_rsp));
    check("rden_count",  64'(rd_n),    64'(exp_rd_cyc));
    check("wren_count",  64'(wr_n),    64'(exp_wr_cyc != 0 ? 1 : 0));
    check("rden_cycle",  64'(rd_cyc),  64'(exp_rd_cyc));
    check("wren_cycle",  64'(wr_cyc),  64'(exp_wr_cyc));
    check("wr_data",     64'(wr_seen), 64'(exp_wr));
    check("rsp_rdata",   64'(bus.rsp_rdata), 64'(exp_rdata));
    check("rsp_err",     64'(bus.rsp_err),   64'(ill));
    check("busy_rsp",    64'(bus.busy),      64'd1);
    last_rdata = bus.rsp_rdata;

    if (w && !ill) ref_mem[idx] = newv;
    check("mem_word", 64'(mem[idx]), 64'({ecc_ref(ref_mem[idx]), ref_mem[idx]}));

    // Hold the response with a competing request pending
    hold = $urandom_range(1, 5);
    bus.req_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
      check("hold_err",   64'(bus.rsp_err),   64'(ill));
      check("hold_ready", 64'(bus.req_ready), 64'd0);
      check("hold_strb",  64'({dccm_rden, dccm_wren}), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    check("retire_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check("post_valid", 64'(bus.rsp_valid), 64'd0);
    check("post_ready", 64'(bus.req_ready), 64'd1);
    check("post_busy",  64'(bus.busy),      64'd0);
  endtask

  // Reset lands in the middle of a byte RMW: memory must stay intact
  task automatic rst_mid_rmw();
    logic [31:0] orig;
    int n;
    orig = ref_mem[16'h0108 >> 2];
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_size  = 2'd0;
    bus.req_addr  = 16'h0109;
    bus.req_wdata = 32'h0000_005A;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_accept", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_wren",  64'(dccm_wren), 64'd0);
    check("rst_rden",  64'(dccm_rden), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",    64'(bus.busy),      64'd0);
    check("rst_rvalid",  64'(bus.rsp_valid), 64'd0);
    check("rst_rerr",    64'(bus.rsp_err),   64'd0);
    check("rst_rdata",   64'(bus.rsp_rdata), 64'd0);
    check("rst_wraddr",  64'(dccm_wr_addr_lo), 64'd0);
    check("rst_wrdata",  64'(dccm_wr_data_lo), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("rst_no_wren", 64'(dccm_wren), 64'd0);
      @(negedge clk);
    end
    check("rst_mem_kept", 64'(mem[16'h0108 >> 2]), 64'({ecc_ref(orig), orig}));
    do_txn(1'b0, 2'd2, 16'h0108, 32'd0);
    check("rst_read_orig", 64'(last_rdata), 64'(orig));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        w;
    logic [1:0]  sz;
    logic [15:0] a;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rvalid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rerr",   64'(bus.rsp_err),   64'd0);
    check("reset_rdata",  64'(bus.rsp_rdata), 64'd0);
    check("reset_busy",   64'(bus.busy),      64'd0);
    check("reset_strb",   64'({dccm_rden, dccm_wren}), 64'd0);
    check("reset_addr",   64'({dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi}), 64'd0);
    check("reset_wdata",  64'(dccm_wr_data_lo | dccm_wr_data_hi), 64'd0);
    check("reset_ready",  64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(bus.req_ready), 64'd1);

    // Preload the working window 0x0100..0x013F
    for (int i = 1; i < 16; i++) do_txn(1'b1, 2'd2, 16'(16'h0100 + 4 * i), $urandom);

    do_txn(1'b1, 2'd2, 16'h0100, 32'hDEAD_BEEF);
    check("dir_ecc", 64'(mem[16'h0100 >> 2][38:32]), 64'(ecc_ref(32'hDEAD_BEEF)));
    do_txn(1'b0, 2'd2, 16'h0100, 32'd0);
    check("dir_word_rd", 64'(last_rdata), 64'hDEAD_BEEF);
    do_txn(1'b1, 2'd0, 16'h0102, 32'h0000_00A5);
    check("dir_byte_merge", 64'(mem[16'h0100 >> 2][31:0]), 64'hDEA5_BEEF);
    do_txn(1'b0, 2'd1, 16'h0102, 32'd0);
    check("dir_half_rd", 64'(last_rdata), 64'h0000_DEA5);
    do_txn(1'b0, 2'd0, 16'h0103, 32'd0);
    check("dir_byte_rd", 64'(last_rdata), 64'h0000_00DE);

    do_txn(1'b0, 2'd2, 16'h0101, 32'd0);
    do_txn(1'b1, 2'd1, 16'h0103, 32'h1234_5678);
    do_txn(1'b0, 2'd3, 16'h0100, 32'd0);
    do_txn(1'b1, 2'd2, 16'h0102, 32'hCAFE_F00D);

    rst_mid_rmw();

    for (int t = 0; t < 300; t++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 16'(16'h0100 + $urandom_range(0, 63));
      do_txn(w, sz, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
